serial_addsub_seq: RTL and testbench
====================================

# serial_addsub_seq

Bit-serial add/subtract sequencer that time-multiplexes a single one-bit full-adder cell over WIDTH-bit operands.
- Processes one bit per clock, LSB first.
- Keeps the inter-bit carry in a flip-flop.
- Reports carry/borrow and signed overflow when done.
- Serves as the low-area arithmetic unit in front of the team's combinational adder/subtractor cells.
- Driven by a simple start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; sole clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = add (a+b), 1 = subtract (a-b).
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  sum/difference; held until next accepted start.
- carry_out  output  1  add: carry out of MSB; sub: borrow (1 when a < b unsigned).
- overflow  output  1  signed two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when start=1.
  - Latch a and b into shift registers.
  - Latch op.
  - Carry flop := op, so subtract computes a + ~b + 1.
  - Bit counter := 0.
- RUN, one bit per cycle:
  - Cell inputs: a_sr[0], b_sr[0] ^ op, carry flop.
  - Cell sum shifts into result shift register at the MSB end.
  - Carry flop := cell carry.
  - Operand registers shift right.
  - Counter increments.
  - On counter == WIDTH-1, go to DONE.
  - Record the carry into the MSB, i.e. the carry flop value before the last bit, for overflow.
- DONE, one cycle, then IDLE.
  - done=1.
  - result = assembled word.
  - carry_out = final carry ^ op (borrow is the inverted carry).
  - overflow = carry into MSB ^ final carry.
- start is ignored in RUN and in DONE; it is not queued.
- a, b and op may change freely after acceptance without effect.
- Reset values: state IDLE; busy 0; done 0; result 0; carry_out 0; overflow 0; internal registers 0.
- Reset mid-operation: the in-flight job is discarded and all outputs return to reset values on the next edge. A start asserted in the same cycle as reset is ignored.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycles 1..WIDTH: busy=1, state RUN.
- Cycle WIDTH+1: done=1, busy=0, outputs valid.
- Cycle WIDTH+2: IDLE. Earliest next accepted start is here, giving throughput of one op per WIDTH+2 cycles.
- result, carry_out and overflow update only at the DONE transition; they stay stable during RUN of the next job.
- All outputs are registered; no combinational input→output path.

## Structure
- Shared package serial_arith_pkg:
  - state enum {IDLE, RUN, DONE}.
  - op encoding constants OP_ADD=0, OP_SUB=1.
  - Function for counter width, $clog2(WIDTH).
- One sub-module, serial_fa_cell: combinational 1-bit full adder (a, b, cin → sum, cout), instantiated once.
- Top-level contents: FSM, counter, three shift registers, carry flop, output registers.

## Test plan
- WIDTH=8, add 0x3C + 0x05:
  - busy high cycles 1–8.
  - done pulse at cycle 9.
  - result 0x41, carry_out 0, overflow 0.
- Sub 0x05 - 0x07 → result 0xFE, carry_out 1 (borrow), overflow 0.
- Add 0x7F + 0x01 → 0x80, overflow 1, carry_out 0.
- Add 0xFF + 0x01 → 0x00, carry_out 1, overflow 0.
- Sub 0x80 - 0x01 → 0x7F, overflow 1, borrow 0.
- Sequencing and reset:
  - start 0x10+0x20; pulse start again at cycle 3 with 0xFF, 0xFF → ignored; result 0x30 at cycle 9.
  - New job: assert reset at its cycle 4 → all outputs 0 next cycle, no done pulse.
  - Fresh start after reset → correct result at +9 cycles.

Source files
------------

// File: rtl/serial_addsub_seq_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Never narrower than one bit, so WIDTH=2 still gets a usable counter.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_addsub_seq_fa_cell.sv
// Combinational one-bit full adder, time-shared across all operand bits.
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell, one bit per clock, LSB first.
module serial_addsub_seq
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             overflow_o
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic cell_sum;
  logic cell_cout;

  // Subtraction feeds the inverted B bit; the +1 comes from the preset carry.
  serial_fa_cell u_fa_cell (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0] ^ (op_q == OP_SUB)),
    .cin_i  (carry_q),
    .sum_o  (cell_sum),
    .cout_o (cell_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    res_sr_d    = res_sr_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          a_sr_d   = a_i;
          b_sr_d   = b_i;
          op_d     = op_i;
          carry_d  = (op_i == OP_SUB);
          cnt_d    = '0;
          res_sr_d = '0;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = {cell_sum, res_sr_q[WIDTH-1:1]};
        carry_d  = cell_cout;
        cnt_d    = cnt_q + 1'b1;
        // On the last bit carry_q is still the carry into the MSB.
        if (cnt_q == LAST) begin
          state_d     = DONE;
          result_d    = {cell_sum, res_sr_q[WIDTH-1:1]};
          carry_out_d = cell_cout ^ op_q;
          overflow_d  = carry_q ^ cell_cout;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_sr_q    <= '0;
      cnt_q       <= '0;
      op_q        <= OP_ADD;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      res_sr_q    <= res_sr_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign carry_out_o = carry_out_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed bench for serial_addsub_seq with a reference model and result scoreboard.
module tb_serial_addsub_seq;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b0;
  logic             start_i = 1'b0;
  logic             op_i = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             carry_out_o;
  logic             overflow_o;

  int   checks = 0;
  int   failures = 0;
  int   cycleCount = 0;
  int   startCycle = 0;
  exp_t sb[$];

  serial_addsub_seq #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .carry_out_o (carry_out_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycleCount <= cycleCount + 1;

  // Reference arithmetic written from the operand values, not from the cell structure.
  function automatic exp_t model(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t           e;
    logic [WIDTH:0] full;
    if (!op) begin
      full     = {1'b0, a} + {1'b0, b};
      e.result = full[WIDTH-1:0];
      e.carry  = full[WIDTH];
      e.ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (e.result[WIDTH-1] != a[WIDTH-1]);
    end else begin
      e.result = a - b;
      e.carry  = (a < b);
      e.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (e.result[WIDTH-1] != a[WIDTH-1]);
    end
    return e;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk_i);
    op_i       = op;
    a_i        = a;
    b_i        = b;
    start_i    = 1'b1;
    startCycle = cycleCount;
    sb.push_back(model(op, a, b));
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    op_i    = ~op;
    a_i     = WIDTH'($urandom);
    b_i     = WIDTH'($urandom);
  endtask

  // Waits (bounded) for done, then checks latency, busy length and the popped expectation.
  task automatic checkOutput(input string tag, input int expBusy);
    int   busySeen = 0;
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 4 * WIDTH && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
      else if (busy_o) busySeen++;
    end
    checkVal({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      e = sb.pop_front();
      checkVal({tag, "_latency"}, 32'(cycleCount - startCycle), 32'(WIDTH + 1));
      checkVal({tag, "_busy_cycles"}, 32'(busySeen), 32'(expBusy));
      checkVal({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
      checkVal({tag, "_result"}, 32'(result_o), 32'(e.result));
      checkVal({tag, "_carry_out"}, 32'(carry_out_o), 32'(e.carry));
      checkVal({tag, "_overflow"}, 32'(overflow_o), 32'(e.ovf));
      @(negedge clk_i);
      checkVal({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkVal({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkVal({tag, "_done"}, 32'(done_o), 32'd0);
    checkVal({tag, "_result"}, 32'(result_o), 32'd0);
    checkVal({tag, "_carry_out"}, 32'(carry_out_o), 32'd0);
    checkVal({tag, "_overflow"}, 32'(overflow_o), 32'd0);
  endtask

  initial begin
    int doneCount;

    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    checkIdleOutputs("reset");

    applyStimulus(1'b0, 8'h3C, 8'h05);
    checkOutput("add_3c_05", WIDTH);
    checkVal("add_3c_05_literal", 32'(result_o), 32'h41);

    applyStimulus(1'b1, 8'h05, 8'h07);
    checkOutput("sub_05_07", WIDTH);
    checkVal("sub_05_07_borrow", 32'(carry_out_o), 32'd1);

    applyStimulus(1'b0, 8'h7F, 8'h01);
    checkOutput("add_7f_01", WIDTH);
    checkVal("add_7f_01_ovf", 32'(overflow_o), 32'd1);

    applyStimulus(1'b0, 8'hFF, 8'h01);
    checkOutput("add_ff_01", WIDTH);
    checkVal("add_ff_01_carry", 32'(carry_out_o), 32'd1);

    applyStimulus(1'b1, 8'h80, 8'h01);
    checkOutput("sub_80_01", WIDTH);
    checkVal("sub_80_01_result", 32'(result_o), 32'h7F);

    // Second start in the middle of a job must be dropped, not queued.
    applyStimulus(1'b0, 8'h10, 8'h20);
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    checkVal("seq_busy_c3", 32'(busy_o), 32'd1);
    start_i = 1'b1;
    op_i    = 1'b0;
    a_i     = 8'hFF;
    b_i     = 8'hFF;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    checkOutput("seq_10_20", WIDTH - 3);
    checkVal("seq_result_literal", 32'(result_o), 32'h30);
    doneCount = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) doneCount++;
    end
    checkVal("seq_no_second_job", 32'(doneCount), 32'd0);
    checkVal("seq_result_held", 32'(result_o), 32'h30);

    // Reset in the middle of a job discards it.
    applyStimulus(1'b0, 8'h11, 8'h22);
    repeat (4) @(negedge clk_i);
    checkVal("rst_busy_c4", 32'(busy_o), 32'd1);
    checkVal("rst_result_stable_in_run", 32'(result_o), 32'h30);
    reset_i = 1'b1;
    @(negedge clk_i);
    checkIdleOutputs("rst_mid");
    reset_i = 1'b0;
    void'(sb.pop_back());
    doneCount = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) doneCount++;
    end
    checkVal("rst_no_done", 32'(doneCount), 32'd0);

    // Start coinciding with reset is ignored.
    @(negedge clk_i);
    reset_i = 1'b1;
    start_i = 1'b1;
    op_i    = 1'b0;
    a_i     = 8'h01;
    b_i     = 8'h02;
    @(negedge clk_i);
    reset_i = 1'b0;
    start_i = 1'b0;
    checkVal("rst_start_ignored", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    checkVal("rst_start_still_idle", 32'(busy_o), 32'd0);

    applyStimulus(1'b0, 8'h11, 8'h22);
    checkOutput("after_reset", WIDTH);
    checkVal("after_reset_literal", 32'(result_o), 32'h33);

    applyStimulus(1'b1, 8'h22, 8'h11);
    checkOutput("sub_22_11", WIDTH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
